// File: rtl/regbank_pkg.sv
// Shared sizes, state encoding and slicing helper for the
// write side of the 16 x 16-bit register bank.
package regbank_pkg;

    localparam int REG_W  = 16;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    function automatic int unsigned slice_lo(input int unsigned k,
                                             input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_write_demux16_dec4to16.sv
// Combinational 4-to-16 one-hot decoder, shared by the write
// port and the clear sweep.
import regbank_pkg::*;

module dec4to16 (
    input  logic [ADDR_W-1:0] in,
    input  logic              en,
    output logic [NREGS-1:0]  out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_demux16.sv
// Write side of the register bank: handshaked write port plus a
// sequential clear-all sweep, with all registers exposed flat.
import regbank_pkg::*;

module regfile_write_demux16 #(
    parameter int WIDTH    = REG_W,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_done,
    input  logic                   clr_req,
    output logic                   busy,
    output logic [NREGS*WIDTH-1:0] regs_flat
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rdy_q, rdy_d;
    logic                busy_q, busy_d;
    logic                done_q;
    logic [WIDTH-1:0]    regs_q [NREGS];

    logic                accept;
    logic [ADDR_W-1:0]   dec_sel;
    logic                dec_en;
    logic [NREGS-1:0]    dec_out;
    logic [NREGS-1:0]    we;
    logic [WIDTH-1:0]    wdata;

    assign accept = wr_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_sel = wr_addr;
        dec_en  = accept;
        wdata   = wr_data;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                dec_sel = cnt_q;
                dec_en  = 1'b1;
                wdata   = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(NREGS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d  = (state_d == IDLE);
        busy_d = (state_d == CLEAR);
    end

    dec4to16 u_dec (
        .in  (dec_sel),
        .en  (dec_en),
        .out (dec_out)
    );

    // Register 0 may be hardwired: its write still completes.
    always_comb begin
        we = dec_out;
        if (ZERO_REG) begin
            we[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= accept;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (we[k]) begin
                    regs_q[k] <= wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[slice_lo(g, WIDTH) +: WIDTH] = regs_q[g];
    end

    assign wr_ready = rdy_q;
    assign busy     = busy_q;
    assign wr_done  = done_q;

endmodule

// File: tb/tb_regfile_write_demux16.sv
// Self-checking bench: two instances (plain and zero-reg) driven in
// lockstep, compared against a cycle-level behavioural model.
module tb_regfile_write_demux16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_valid;
    logic [3:0]   wr_addr;
    logic [15:0]  wr_data;
    logic         clr_req;

    logic         rdy_a, done_a, busy_a;
    logic         rdy_b, done_b, busy_b;
    logic [255:0] flat_a, flat_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] ma [16];
    logic [15:0] mb [16];
    bit          m_ready;
    bit          m_done;
    int          m_left;

    always #5 clk = ~clk;

    regfile_write_demux16 #(.WIDTH(16), .ZERO_REG(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_a),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(done_a),
        .clr_req(clr_req), .busy(busy_a), .regs_flat(flat_a)
    );

    regfile_write_demux16 #(.WIDTH(16), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_b),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(done_b),
        .clr_req(clr_req), .busy(busy_b), .regs_flat(flat_b)
    );

    function automatic logic [255:0] pack(input logic [15:0] m [16]);
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = m[k];
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready_a"}, 256'(rdy_a), 256'(m_ready));
        check({tag, ".ready_b"}, 256'(rdy_b), 256'(m_ready));
        check({tag, ".busy"}, 256'({busy_a, busy_b}),
              256'({2{m_left > 0}}));
        check({tag, ".done"}, 256'({done_a, done_b}), 256'({2{m_done}}));
        check({tag, ".regs_a"}, flat_a, pack(ma));
        check({tag, ".regs_b"}, flat_b, pack(mb));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            ma[k] = '0;
            mb[k] = '0;
        end
        m_ready = 0;
        m_done  = 0;
        m_left  = 0;
    endtask

    // Model of one rising edge, from the inputs held before it.
    task automatic model_edge();
        bit acc;
        acc = wr_valid && m_ready;
        m_done = acc;
        if (m_left > 0) begin
            ma[16 - m_left] = '0;
            mb[16 - m_left] = '0;
            m_left--;
            m_ready = (m_left == 0);
        end else begin
            if (acc) begin
                ma[wr_addr] = wr_data;
                if (wr_addr != 0) mb[wr_addr] = wr_data;
            end
            if (clr_req) begin
                m_left  = 16;
                m_ready = 0;
            end else begin
                m_ready = 1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [3:0] a,
                        input logic [15:0] d, input bit c,
                        input string tag);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        clr_req  = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 4'h0, 16'h0, 0, tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        idle(1, "post_reset");

        step(1, 4'd5, 16'hA5A5, 0, "wr5");
        idle(2, "wr5_after");

        for (int k = 0; k < 16; k++)
            step(1, 4'(k), 16'h1000 + 16'(k), 0, "b2b");
        idle(1, "b2b_after");

        for (int k = 0; k < 16; k++)
            step(1, 4'(k), 16'hFFFF, 0, "preload");
        step(0, 4'h0, 16'h0, 1, "clr_start");
        for (int i = 0; i < 17; i++)
            step(0, 4'h0, 16'h0, i == 4, "sweep");

        step(1, 4'd3, 16'h1234, 1, "wr_and_clr");
        for (int i = 0; i < 15; i++)
            step(1, 4'd9, 16'h5A5A, 0, "held_wr");
        step(1, 4'd9, 16'h5A5A, 0, "held_last");
        step(1, 4'd9, 16'h5A5A, 0, "held_accept");
        idle(2, "held_after");

        for (int k = 0; k < 16; k++)
            step(1, 4'(k), 16'hC000 ^ 16'(k * 7), 0, "refill");
        step(0, 4'h0, 16'h0, 1, "clr2");
        for (int i = 0; i < 7; i++) step(0, 4'h0, 16'h0, 0, "sweep2");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        #3;
        rst_n = 1'b1;
        idle(1, "rel2");
        step(1, 4'd7, 16'h7777, 0, "wr_after_rst");

        step(1, 4'd0, 16'hBEEF, 0, "zr_wr0");
        step(1, 4'd1, 16'hBEEF, 0, "zr_wr1");
        idle(1, "zr_after");

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 16'($urandom), $urandom_range(0, 24) == 0, "rand");
        idle(18, "drain");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
